// File: rtl/rc4_pkg.sv
// rc4_pkg -- shared definitions for the RC4 memory handler and its requesters.
//   mem_sel encodings (same values on the handler side),
//   decrypt FSM state enum, default message length,
//   is_valid_char(): lowercase letter or space check on a decrypted byte.
package rc4_pkg;

    localparam logic [1:0] MEM_NONE = 2'b00;
    localparam logic [1:0] MEM_WORK = 2'b01;
    localparam logic [1:0] MEM_ROM  = 2'b10;
    localparam logic [1:0] MEM_DEC  = 2'b11;

    localparam int DEF_MSG_LEN = 32;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_INC_I,
        ST_RD_SI,
        ST_RD_SJ,
        ST_WR_I,
        ST_WR_J,
        ST_RD_F,
        ST_RD_ENC,
        ST_WR_DEC,
        ST_DONE
    } dec_state_e;

    function automatic logic is_valid_char(input logic [7:0] b);
        return ((b >= 8'h61) && (b <= 8'h7A)) || (b == 8'h20);
    endfunction

endpackage

// File: rtl/rc4_decrypt_fsm.sv
// rc4_decrypt_fsm -- RC4 decrypt-stage requester.
// Generates the keystream from working RAM S (already shuffled), XORs it with
// each encrypted ROM byte and writes the result to decrypted-message RAM.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start           begin decryption (only looked at in IDLE)
//   busy            high in every non-IDLE state
//   mem_sel         target memory (MEM_NONE/WORK/ROM/DEC)
//   address, data   request address / write data
//   wren            one-cycle write strobe
//   rdata           read data returned by the handler
//   done            one-cycle completion pulse
//   fail            invalid decrypted character seen; held until next start
module rc4_decrypt_fsm
    import rc4_pkg::*;
#(
    parameter int MSG_LEN     = DEF_MSG_LEN,
    parameter int RD_LAT      = 2,
    parameter int CHECK_CHARS = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       busy,
    output logic [1:0] mem_sel,
    output logic [7:0] address,
    output logic [7:0] data,
    output logic       wren,
    input  logic [7:0] rdata,
    output logic       done,
    output logic       fail
);

    localparam int             CW      = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [CW-1:0]  RD_LAST = CW'(RD_LAT - 1);
    localparam logic [4:0]     K_LAST  = 5'(MSG_LEN - 1);

    dec_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    i_q, i_d, j_q, j_d;
    logic [7:0]    si_q, si_d, sj_q, sj_d;
    logic [7:0]    f_q, f_d, enc_q, enc_d;
    logic [4:0]    k_q, k_d;
    logic          fail_q, fail_d;

    logic          rd_last;
    logic [7:0]    dec_byte;

    // Read states hold the address for RD_LAT cycles; rdata is used only
    // on the cycle where the wait counter reaches zero.
    assign rd_last  = (cnt_q == '0);
    assign dec_byte = f_q ^ enc_q;
    assign fail     = fail_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            i_q     <= '0;
            j_q     <= '0;
            si_q    <= '0;
            sj_q    <= '0;
            f_q     <= '0;
            enc_q   <= '0;
            k_q     <= '0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            i_q     <= i_d;
            j_q     <= j_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
            f_q     <= f_d;
            enc_q   <= enc_d;
            k_q     <= k_d;
            fail_q  <= fail_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        i_d     = i_q;
        j_d     = j_q;
        si_d    = si_q;
        sj_d    = sj_q;
        f_d     = f_q;
        enc_d   = enc_q;
        k_d     = k_q;
        fail_d  = fail_q;
        busy    = (state_q != ST_IDLE);
        mem_sel = MEM_NONE;
        address = 8'h00;
        data    = 8'h00;
        wren    = 1'b0;
        done    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    i_d     = 8'h00;
                    j_d     = 8'h00;
                    k_d     = 5'd0;
                    fail_d  = 1'b0;
                    state_d = ST_INC_I;
                end
            end
            ST_INC_I: begin
                i_d     = i_q + 8'd1;
                cnt_d   = RD_LAST;
                state_d = ST_RD_SI;
            end
            ST_RD_SI: begin
                mem_sel = MEM_WORK;
                address = i_q;
                if (rd_last) begin
                    si_d    = rdata;
                    j_d     = j_q + rdata;
                    cnt_d   = RD_LAST;
                    state_d = ST_RD_SJ;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RD_SJ: begin
                mem_sel = MEM_WORK;
                address = j_q;
                if (rd_last) begin
                    sj_d    = rdata;
                    state_d = ST_WR_I;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            // Swap: i==j needs no special case since si==sj then.
            ST_WR_I: begin
                mem_sel = MEM_WORK;
                address = i_q;
                data    = sj_q;
                wren    = 1'b1;
                state_d = ST_WR_J;
            end
            ST_WR_J: begin
                mem_sel = MEM_WORK;
                address = j_q;
                data    = si_q;
                wren    = 1'b1;
                cnt_d   = RD_LAST;
                state_d = ST_RD_F;
            end
            ST_RD_F: begin
                mem_sel = MEM_WORK;
                address = si_q + sj_q;
                if (rd_last) begin
                    f_d     = rdata;
                    cnt_d   = RD_LAST;
                    state_d = ST_RD_ENC;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RD_ENC: begin
                mem_sel = MEM_ROM;
                address = {3'b000, k_q};
                if (rd_last) begin
                    enc_d   = rdata;
                    state_d = ST_WR_DEC;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_WR_DEC: begin
                mem_sel = MEM_DEC;
                address = {3'b000, k_q};
                data    = dec_byte;
                wren    = 1'b1;
                // The failing byte itself is still written before aborting.
                if ((CHECK_CHARS != 0) && !is_valid_char(dec_byte)) begin
                    fail_d  = 1'b1;
                    state_d = ST_DONE;
                end else if (k_q == K_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    k_d     = k_q + 5'd1;
                    state_d = ST_INC_I;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule
